// File: rtl/cnn_pkg.sv
// cnn_pkg: shared flatten-stage state type, default sizes and index-width helper.
package cnn_pkg;
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} flat_state_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int DEF_DATA_WIDTH       = 8;
   localparam int DEF_NUM_FEATURES     = 3;
   localparam int DEF_POOLED_HEIGHT    = 12;
   localparam int DEF_POOLED_WIDTH     = 12;
   localparam int DEF_FLATTENED_LENGTH = 432;
   localparam int DEF_FEAT_W           = idx_w(DEF_NUM_FEATURES);
   localparam int DEF_ROW_W            = idx_w(DEF_POOLED_HEIGHT);
   localparam int DEF_COL_W            = idx_w(DEF_POOLED_WIDTH);
   localparam int DEF_IDX_W            = idx_w(DEF_FLATTENED_LENGTH);
endpackage

// File: rtl/flatten_skid_fifo.sv
// flatten_skid_fifo: 2-entry {data, index} FIFO; reset flushes it.
module flatten_skid_fifo #(
   parameter int DW = 8,
   parameter int IW = 4
) (
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic signed [DW-1:0] i_data,
   input  logic [IW-1:0]        i_index,
   output logic signed [DW-1:0] o_data,
   output logic [IW-1:0]        o_index,
   output logic [1:0]           o_count
);
   logic signed [DW-1:0] r_data [2];
   logic [IW-1:0]        r_index [2];
   logic                 r_wp;
   logic                 r_rp;
   logic [1:0]           r_count;
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_wp    <= 1'b0;
         r_rp    <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) begin
            r_data[r_wp]  <= i_data;
            r_index[r_wp] <= i_index;
            r_wp          <= ~r_wp;
         end
         if (i_pop) r_rp <= ~r_rp;
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end
   assign o_data  = r_data[r_rp];
   assign o_index = r_index[r_rp];
   assign o_count = r_count;
endmodule

// File: rtl/flatten_stream_ctrl.sv
// flatten_stream_ctrl: raster-order reader of the pooled buffer streaming {data, index} to the FC stage.
// Optional FLATTEN_RELU_EN clamps negative elements to zero as they enter the FIFO.
module flatten_stream_ctrl
   import cnn_pkg::*;
#(
   parameter int NUM_FEATURES     = DEF_NUM_FEATURES,
   parameter int POOLED_HEIGHT    = DEF_POOLED_HEIGHT,
   parameter int POOLED_WIDTH     = DEF_POOLED_WIDTH,
   parameter int FLATTENED_LENGTH = DEF_FLATTENED_LENGTH,
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH
) (
   input  logic                               i_clock,
   input  logic                               i_reset_n,
   input  logic                               i_start,
   output logic                               o_busy,
   output logic                               o_done,
   output logic                               o_rd_en,
   output logic [idx_w(NUM_FEATURES)-1:0]     o_rd_feature,
   output logic [idx_w(POOLED_HEIGHT)-1:0]    o_rd_row,
   output logic [idx_w(POOLED_WIDTH)-1:0]     o_rd_col,
   input  logic signed [DATA_WIDTH-1:0]       i_rd_data,
   output logic                               o_out_valid,
   input  logic                               i_out_ready,
   output logic signed [DATA_WIDTH-1:0]       o_out_data,
   output logic [idx_w(FLATTENED_LENGTH)-1:0] o_out_index
);
   localparam int FW = idx_w(NUM_FEATURES);
   localparam int RW = idx_w(POOLED_HEIGHT);
   localparam int CW = idx_w(POOLED_WIDTH);
   localparam int LW = idx_w(FLATTENED_LENGTH);
   if (FLATTENED_LENGTH != NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH) begin : g_bad_len
      $error("FLATTENED_LENGTH must equal NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH");
   end
   flat_state_t                 r_state;
   logic                        r_busy;
   logic                        r_done;
   logic                        r_inflight;
   logic [FW-1:0]               r_feat;
   logic [RW-1:0]               r_row;
   logic [CW-1:0]               r_col;
   logic [LW-1:0]               r_idx;
   logic [LW-1:0]               r_inf_idx;
   logic                        w_pop;
   logic                        w_push;
   logic                        w_empty;
   logic                        w_col_wrap;
   logic                        w_row_wrap;
   logic                        w_feat_wrap;
   logic [1:0]                  w_count;
   logic [2:0]                  w_level;
   logic signed [DATA_WIDTH-1:0] w_in_data;
   logic signed [DATA_WIDTH-1:0] w_fifo_data;
   logic [LW-1:0]               w_fifo_index;
`ifdef FLATTEN_RELU_EN
   assign w_in_data = i_rd_data[DATA_WIDTH-1] ? '0 : i_rd_data;
`else
   assign w_in_data = i_rd_data;
`endif
   // An empty FIFO lets the returning read go straight to the output, giving start->valid in two cycles.
   assign w_empty     = (w_count == 2'd0);
   assign o_out_valid = !w_empty || r_inflight;
   assign o_out_data  = !w_empty ? w_fifo_data : (r_inflight ? w_in_data : '0);
   assign o_out_index = !w_empty ? w_fifo_index : (r_inflight ? r_inf_idx : '0);
   assign w_pop       = o_out_valid && i_out_ready;
   assign w_push      = r_inflight && !(w_empty && w_pop);
   assign w_level     = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
   assign o_rd_en     = (r_state == STREAM) && (w_level < 3'd2);
   assign w_col_wrap  = (r_col == CW'(POOLED_WIDTH - 1));
   assign w_row_wrap  = (r_row == RW'(POOLED_HEIGHT - 1));
   assign w_feat_wrap = (r_feat == FW'(NUM_FEATURES - 1));
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_rd_feature = r_feat;
   assign o_rd_row     = r_row;
   assign o_rd_col     = r_col;
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_inflight <= 1'b0;
         r_feat     <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_idx      <= '0;
         r_inf_idx  <= '0;
      end else begin
         r_inflight <= o_rd_en;
         if (o_rd_en) begin
            r_inf_idx <= r_idx;
            r_idx     <= r_idx + 1'b1;
            r_col     <= w_col_wrap ? '0 : r_col + 1'b1;
            if (w_col_wrap) r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            if (w_col_wrap && w_row_wrap) r_feat <= w_feat_wrap ? '0 : r_feat + 1'b1;
         end
         case (r_state)
            IDLE: if (i_start) begin
               r_state <= STREAM;
               r_busy  <= 1'b1;
               r_idx   <= '0;
            end
            STREAM: if (o_rd_en && w_col_wrap && w_row_wrap && w_feat_wrap) r_state <= DRAIN;
            DRAIN: if (w_pop && o_out_index == LW'(FLATTENED_LENGTH - 1)) begin
               r_state <= DONE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   flatten_skid_fifo #(.DW(DATA_WIDTH), .IW(LW)) u_fifo (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_push    (w_push),
      .i_pop     (w_pop && !w_empty),
      .i_data    (w_in_data),
      .i_index   (r_inf_idx),
      .o_data    (w_fifo_data),
      .o_index   (w_fifo_index),
      .o_count   (w_count)
   );
endmodule

// File: tb/tb_flatten_stream_ctrl.sv
// tb_flatten_stream_ctrl: directed passes with a scoreboard of expected {index, data} per handshake.
module tb_flatten_stream_ctrl;
   localparam int F = 2, H = 2, W = 3, L = 12, DW = 8;
   typedef struct {int idx; int data;} exp_t;
   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 start = 1'b0;
   logic                 ready = 1'b1;
   logic                 busy, done, rd_en, out_valid;
   logic [0:0]           rd_f;
   logic [0:0]           rd_r;
   logic [1:0]           rd_c;
   logic signed [DW-1:0] rd_data = '0;
   logic signed [DW-1:0] out_data;
   logic [3:0]           out_index;
   logic signed [DW-1:0] mem [L];
   logic signed [DW-1:0] got [L];
   logic [3:0]           pat = 4'b1001;
   exp_t                 q[$];
   int                   n_checks = 0, n_fail = 0, cyc = 0;
   int                   rd_cnt = 0, hs_cnt = 0, done_cnt = 0, first_hs = 0, last_hs = 0;
   bit                   rmode = 1'b0;

   flatten_stream_ctrl #(.NUM_FEATURES(F), .POOLED_HEIGHT(H), .POOLED_WIDTH(W),
                         .FLATTENED_LENGTH(L), .DATA_WIDTH(DW)) dut (
      .i_clock(clk), .i_reset_n(reset_n), .i_start(start), .o_busy(busy), .o_done(done),
      .o_rd_en(rd_en), .o_rd_feature(rd_f), .o_rd_row(rd_r), .o_rd_col(rd_c), .i_rd_data(rd_data),
      .o_out_valid(out_valid), .i_out_ready(ready), .o_out_data(out_data), .o_out_index(out_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= mem[int'(rd_f) * H * W + int'(rd_r) * W + int'(rd_c)];

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model(input logic signed [DW-1:0] v);
`ifdef FLATTEN_RELU_EN
      return (v < 0) ? 0 : int'(v);
`else
      return int'(v);
`endif
   endfunction

   // Scoreboard: a honoured start queues the whole expected pass; handshakes pop and compare.
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
         q.delete();
         rd_cnt = 0;
         hs_cnt = 0;
      end else begin
         if (start && !busy && !done) begin
            q.delete();
            for (int i = 0; i < L; i++) q.push_back('{idx: i, data: model(mem[i])});
            rd_cnt = 0;
            hs_cnt = 0;
            done_cnt = 0;
         end
         check("outstanding_le2", 32'(rd_cnt - hs_cnt <= 2), 1);
         if (rd_en) begin
            check("rd_feature", 32'(rd_f), rd_cnt / (H * W));
            check("rd_row", 32'(rd_r), (rd_cnt % (H * W)) / W);
            check("rd_col", 32'(rd_c), rd_cnt % W);
            rd_cnt++;
         end
         if (out_valid) begin
            if (q.size() == 0) check("unexpected_out", 32'(out_index), -1);
            else begin
               check("out_index", 32'(out_index), q[0].idx);
               check("out_data", 32'(out_data), q[0].data);
               if (ready) begin
                  got[q[0].idx] = out_data;
                  void'(q.pop_front());
                  if (hs_cnt == 0) first_hs = cyc;
                  last_hs = cyc;
                  hs_cnt++;
               end
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_last", cyc - last_hs, 1);
            check("done_hs_count", hs_cnt, L);
         end
      end
   end

   initial begin
      int k = 0;
      forever begin
         @(posedge clk);
         #1 ready = rmode ? pat[k % 4] : 1'b1;
         k++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check_idle(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_rd_en"}, 32'(rd_en), 0);
      check({tag, "_valid"}, 32'(out_valid), 0);
      check({tag, "_rd_f"}, 32'(rd_f), 0);
      check({tag, "_rd_r"}, 32'(rd_r), 0);
      check({tag, "_rd_c"}, 32'(rd_c), 0);
      check({tag, "_data"}, 32'(out_data), 0);
      check({tag, "_index"}, 32'(out_index), 0);
   endtask

   task automatic start_pass();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic finish_pass(input string tag, input int budget, input bit consec);
      for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
      repeat (4) @(posedge clk);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_handshakes"}, hs_cnt, L);
      check({tag, "_reads"}, rd_cnt, L);
      check({tag, "_queue_left"}, q.size(), 0);
      check({tag, "_busy_end"}, 32'(busy), 0);
      if (consec) check({tag, "_back_to_back"}, last_hs - first_hs, L - 1);
   endtask

   initial begin
      logic signed [31:0] exp4 [4];
      for (int i = 0; i < L; i++) mem[i] = DW'(10 * (i / (H * W)) + 3 * ((i % (H * W)) / W) + i % W);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;

      start_pass();
      @(negedge clk);
      check("lat_rd_en", 32'(rd_en), 1);
      check("lat_no_valid_yet", 32'(out_valid), 0);
      check("lat_busy", 32'(busy), 1);
      @(negedge clk);
      check("lat_valid", 32'(out_valid), 1);
      check("lat_first_index", 32'(out_index), 0);
      start_pass();
      finish_pass("p1", 100, 1'b1);

      rmode = 1'b1;
      start_pass();
      finish_pass("bp", 300, 1'b0);
      rmode = 1'b0;

      start_pass();
      for (int i = 0; i < 50 && hs_cnt < 4; i++) @(posedge clk);
      check("rst_reached_4", 32'(hs_cnt >= 4), 1);
      #1 reset_n = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check_idle("midrst");
      start_pass();
      finish_pass("restart", 100, 1'b1);

      mem[0] = 8'shFB;
      mem[1] = 8'sd7;
      mem[2] = 8'sh80;
      mem[3] = 8'sd127;
`ifdef FLATTEN_RELU_EN
      exp4 = '{0, 7, 0, 127};
`else
      exp4 = '{-5, 7, -128, 127};
`endif
      start_pass();
      finish_pass("relu", 100, 1'b1);
      for (int i = 0; i < 4; i++) check($sformatf("relu_val%0d", i), 32'(got[i]), exp4[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
